// File: rtl/pc_pkg.sv
// Shared op encoding and request priority for the PC / return-stack block.
// Optional relative-jump port is enabled by defining PC_REL_EN.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_RES,
    OP_LOAD,
    OP_REL,
    OP_CALL,
    OP_RET,
    OP_INC,
    OP_HOLD
  } pc_op_t;

  // Exactly one op wins per edge; losers are dropped.
  function automatic pc_op_t pc_next_op(
    input logic res,
    input logic load,
    input logic rel,
    input logic call,
    input logic ret,
    input logic inc
  );
    pc_op_t op;
    op = OP_HOLD;
    if (res)       op = OP_RES;
    else if (load) op = OP_LOAD;
    else if (rel)  op = OP_REL;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (inc)  op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses; reset clears only the occupancy count.
// Caller guarantees push and pop are never asserted together.
module ret_stack #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            wdata,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] widx;
  logic [PW-1:0] tidx;

  assign widx  = depth[PW-1:0];
  assign tidx  = depth[PW-1:0] - PW'(1);
  assign top   = mem[tidx];
  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);

  always_ff @(posedge clk) begin
    if (res) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!res && push && !full) begin
      mem[widx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with load/inc/call/ret and a return-address stack.
// Define PC_REL_EN to add the rel port (out <= out + signed in).
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int          AW       = 5,
  parameter int          DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   load,
  input  logic                   inc,
  input  logic                   call,
  input  logic                   ret,
`ifdef PC_REL_EN
  input  logic                   rel,
`endif
  input  logic [AW-1:0]          in,
  output logic [AW-1:0]          out,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  logic          rel_req;
  pc_op_t        op;
  logic          do_push;
  logic          do_pop;
  logic          fault;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] stk_top;
  logic [AW-1:0] pc_nxt;

`ifdef PC_REL_EN
  assign rel_req = rel;
`else
  assign rel_req = 1'b0;
`endif

  assign op      = pc_next_op(res, load, rel_req, call, ret, inc);
  assign pc_inc  = out + AW'(1);
  assign do_push = (op == OP_CALL) && !full;
  assign do_pop  = (op == OP_RET) && !empty;
  assign fault   = ((op == OP_CALL) && full) ||
                   ((op == OP_RET) && empty);

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stk (
    .clk   (clk),
    .res   (res),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (pc_inc),
    .top   (stk_top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Faulted call/ret fall through to hold.
  always_comb begin
    pc_nxt = out;
    unique case (op)
      OP_RES:  pc_nxt = RESET_PC;
      OP_LOAD: pc_nxt = in;
      OP_REL:  pc_nxt = out + in;
      OP_CALL: if (do_push) pc_nxt = in;
      OP_RET:  if (do_pop) pc_nxt = stk_top;
      OP_INC:  pc_nxt = pc_inc;
      OP_HOLD: pc_nxt = out;
      default: pc_nxt = out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      out <= RESET_PC;
    end else begin
      out <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      err <= 1'b0;
    end else if (fault) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack at AW=5, DEPTH=4, RESET_PC=0.
// Rel-jump checks run only when PC_REL_EN is defined.
module tb_pc_call_stack;

  localparam logic [5:0] R  = 6'b100000;
  localparam logic [5:0] L  = 6'b010000;
  localparam logic [5:0] RL = 6'b001000;
  localparam logic [5:0] C  = 6'b000100;
  localparam logic [5:0] T  = 6'b000010;
  localparam logic [5:0] I  = 6'b000001;
  localparam logic [5:0] N  = 6'b000000;

  typedef struct packed {
    logic [5:0] c;
    logic [4:0] in;
    logic [4:0] eo;
    logic [2:0] ed;
    logic       ee;
  } step_t;

  typedef struct packed {
    logic [4:0] o;
    logic [2:0] d;
    logic       f;
    logic       e;
    logic       er;
  } exp_t;

  logic       clk = 1'b0;
  logic       res, load, inc, call, ret, rel;
  logic [4:0] in;
  logic [4:0] out;
  logic [2:0] depth;
  logic       full, empty, err;

  int n_tests = 0;
  int n_fail  = 0;

  step_t stq [$];
  exp_t  sbq [$];

  always #5 clk = ~clk;

  pc_call_stack #(
    .AW       (5),
    .DEPTH    (4),
    .RESET_PC (5'd0)
  ) dut (
    .clk   (clk),
    .res   (res),
    .load  (load),
    .inc   (inc),
    .call  (call),
    .ret   (ret),
`ifdef PC_REL_EN
    .rel   (rel),
`endif
    .in    (in),
    .out   (out),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  function automatic step_t mk(
    input logic [5:0] c, input logic [4:0] i,
    input logic [4:0] eo, input logic [2:0] ed, input logic ee
  );
    step_t s;
    s = '{c: c, in: i, eo: eo, ed: ed, ee: ee};
    return s;
  endfunction

  task automatic drive(input step_t s);
    {res, load, rel, call, ret, inc} = s.c;
    in = s.in;
    sbq.push_back('{o: s.eo, d: s.ed, f: (s.ed == 3'd4),
                    e: (s.ed == 3'd0), er: s.ee});
  endtask

  task automatic idle();
    {res, load, rel, call, ret, inc} = 6'b0;
    in = 5'd0;
  endtask

  task automatic test_reset();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(R | C, 5'd7, 5'd0, 3'd0, 1'b0));
    stq.push_back(mk(N, 5'd9, 5'd0, 3'd0, 1'b0));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL reset: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

  task automatic test_load_inc();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(L, 5'd1, 5'd1, 3'd0, 1'b0));
    stq.push_back(mk(I, 5'd0, 5'd2, 3'd0, 1'b0));
    stq.push_back(mk(I, 5'd0, 5'd3, 3'd0, 1'b0));
    stq.push_back(mk(L, 5'd31, 5'd31, 3'd0, 1'b0));
    stq.push_back(mk(I, 5'd0, 5'd0, 3'd0, 1'b0));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL load_inc: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

  task automatic test_nested();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(L, 5'd3, 5'd3, 3'd0, 1'b0));
    stq.push_back(mk(C, 5'd10, 5'd10, 3'd1, 1'b0));
    stq.push_back(mk(C, 5'd20, 5'd20, 3'd2, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd11, 3'd1, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd4, 3'd0, 1'b0));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL nested: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

  task automatic test_overflow();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(R, 5'd0, 5'd0, 3'd0, 1'b0));
    stq.push_back(mk(C, 5'd1, 5'd1, 3'd1, 1'b0));
    stq.push_back(mk(C, 5'd2, 5'd2, 3'd2, 1'b0));
    stq.push_back(mk(C, 5'd3, 5'd3, 3'd3, 1'b0));
    stq.push_back(mk(C, 5'd4, 5'd4, 3'd4, 1'b0));
    stq.push_back(mk(C, 5'd7, 5'd4, 3'd4, 1'b1));
    stq.push_back(mk(T, 5'd0, 5'd4, 3'd3, 1'b1));
    stq.push_back(mk(T, 5'd0, 5'd3, 3'd2, 1'b1));
    stq.push_back(mk(R, 5'd0, 5'd0, 3'd0, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd0, 3'd0, 1'b1));
    stq.push_back(mk(I, 5'd0, 5'd1, 3'd0, 1'b1));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL over_under: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

  task automatic test_priority();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(R, 5'd0, 5'd0, 3'd0, 1'b0));
    stq.push_back(mk(L | C | I, 5'd9, 5'd9, 3'd0, 1'b0));
    stq.push_back(mk(C | T, 5'd15, 5'd15, 3'd1, 1'b0));
    stq.push_back(mk(T | I, 5'd0, 5'd10, 3'd0, 1'b0));
    stq.push_back(mk(C, 5'd6, 5'd6, 3'd1, 1'b0));
    stq.push_back(mk(R | C, 5'd7, 5'd0, 3'd0, 1'b0));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL priority: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(C, 5'd12, 5'd12, 3'd1, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd1, 3'd0, 1'b0));
    stq.push_back(mk(C, 5'd25, 5'd25, 3'd1, 1'b0));
    stq.push_back(mk(C, 5'd30, 5'd30, 3'd2, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd26, 3'd1, 1'b0));
    stq.push_back(mk(T, 5'd0, 5'd2, 3'd0, 1'b0));
    stq.push_back(mk(T | I, 5'd0, 5'd2, 3'd0, 1'b1));
    stq.push_back(mk(N, 5'd17, 5'd2, 3'd0, 1'b1));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL back_to_back: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask

`ifdef PC_REL_EN
  task automatic test_rel();
    step_t s;
    exp_t  e;
    stq = {};
    stq.push_back(mk(R, 5'd0, 5'd0, 3'd0, 1'b0));
    stq.push_back(mk(L, 5'd10, 5'd10, 3'd0, 1'b0));
    stq.push_back(mk(RL, 5'b11110, 5'd8, 3'd0, 1'b0));
    stq.push_back(mk(RL | L, 5'd3, 5'd3, 3'd0, 1'b0));
    stq.push_back(mk(RL | C, 5'd1, 5'd4, 3'd0, 1'b0));
    stq.push_back(mk(RL, 5'd30, 5'd2, 3'd0, 1'b0));
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_tests++;
      if (out !== e.o || depth !== e.d || full !== e.f ||
          empty !== e.e || err !== e.er) begin
        n_fail++;
        $display("FAIL rel: got out=%0d depth=%0d full=%b empty=%b err=%b, need out=%0d depth=%0d full=%b empty=%b err=%b",
                 out, depth, full, empty, err, e.o, e.d, e.f, e.e, e.er);
      end
    end
  endtask
`endif

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_load_inc();
    test_nested();
    test_overflow();
    test_priority();
    test_back_to_back();
`ifdef PC_REL_EN
    test_rel();
`endif
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program-counter register for the CPU fetch path, with a built-in return-address stack.
- Extends plain load/increment/reset behaviour to configurable address width, subroutine call/return and stack full/empty status.
- Sits between control unit and instruction-memory address bus; one update per clock.

Parameters:
- AW, 5, PC/address width in bits (≥2).
- DEPTH, 4, return-stack entries (power of 2, ≥2).
- RESET_PC, 0, value loaded into out on reset (AW bits).

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  synchronous, active-high reset.
- load  in  1  absolute jump: out <= in.
- inc  in  1  out <= out + 1.
- call  in  1  push out+1, then out <= in.
- ret  in  1  out <= top of stack, pop.
- in  in  AW  jump/call target (offset when rel is used).
- out  out  AW  current PC.
- depth  out  $clog2(DEPTH)+1  number of valid stack entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- err  out  1  sticky stack-fault flag.

Behaviour:
- Interface: one clock, clk. Reset res is synchronous and active-high. No asynchronous or combinational clearing of out.
- Reset at posedge with res=1:
  - out=RESET_PC, depth=0, full=0, empty=1, err=0.
  - Stack contents are don't-care.
  - Reset takes priority over everything, including mid call/ret.
- Priority per edge is res > load > [rel] > call > ret > inc > hold. Exactly one action executes per cycle; lower-priority requests are ignored, not queued.
- load: out <= in. Stack untouched.
- call, not full: stack[depth] <= out+1 (mod 2^AW); depth++; out <= in.
- call, full: no push, no jump, out holds, err <= 1.
- ret, not empty: out <= stack[depth-1]; depth--.
- ret, empty: out holds, err <= 1.
- inc: out <= out+1. Wraps 2^AW-1 → 0 with no flag.
- hold when no request.
- Latency and outputs:
  - All actions are visible on out one cycle after the sampling edge.
  - full, empty and depth are registered or derived from the registered depth. They are consistent with out in the same cycle.
- err is sticky until res. It never blocks later legal operations.
- Back-to-back call/ret on consecutive cycles is legal. The ret in cycle N+1 returns the address pushed in cycle N.
- Arithmetic is unsigned modulo 2^AW. The return address is out+1 computed at the call edge.

Optional Feature:
- Macro: PC_REL_EN.
- Defined:
  - Adds input port rel (1 bit).
  - rel=1 gives out <= out + in, where in is two's-complement AW-bit, wrapping mod 2^AW.
  - Priority is below load and above call.
  - Stack is untouched.
- Undefined:
  - Port rel does not exist.
  - Behaviour is identical to the above with rel treated as 0.

Decomposition:
- Package pc_pkg holds:
  - enum pc_op_t {OP_RES, OP_LOAD, OP_REL, OP_CALL, OP_RET, OP_INC, OP_HOLD}.
  - Function pc_next_op(res, load, rel, call, ret, inc) implementing the priority.
- Sub-module ret_stack(DEPTH, AW):
  - Signals: push/pop, wdata, top, depth, full, empty.
  - Synchronous reset clears depth only.
- Top level:
  - PC register.
  - Op decode.
  - Error logic.

Test Plan (AW=5, DEPTH=4):
- Reset then load: res=1 for one cycle, then load=1, in=5'b00001 → out=0 with empty=1 after res; next edge out=1; then inc=1 for 2 cycles → out=2, 3.
- Wrap: load in=31, then inc → out=0, err=0.
- Nested calls:
  - Sequence: out=3; call in=10; call in=20; ret; ret.
  - Pushes: return addresses 4 and 11.
  - out sequence: 10, 20, 11, 4; depth 1, 2, 1, 0.
- Overflow and underflow:
  - 4 calls → full=1; 5th call in=7 → out unchanged, err=1, depth=4.
  - After res: ret on empty → out holds, err=1.
- Priority:
  - load=1, call=1, inc=1, in=9 → out=9, depth unchanged.
  - call=1, ret=1 → call executes.
  - res=1 with call=1 → out=RESET_PC, depth=0.
- PC_REL_EN: out=10, rel=1, in=5'b11110 (−2) → out=8; rel=1 with load=1, in=3 → out=3.
